rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Board-level reset controller. Synchronizes asynchronous "PLL locked" and external reset-button inputs into the clk domain with 2-flop synchronizers.
- Filters the synchronized inputs, then releases NUM_OUT downstream active-low resets one at a time, in index order, with a fixed gap between releases.
- Any lock loss or software reset request re-asserts all outputs at once and restarts the sequence.
- Sits between the clock generator and the camera, memory and video domains.

Parameters:
- NUM_OUT, 3: number of sequenced reset outputs; must be >= 1.
- DELAY_W, 8: width of the hold/stagger counter.
- DELAY, 16: minimum ASSERT hold, and gap between successive releases, in clk cycles; 1 <= DELAY <= 2^DELAY_W-1.
- LOCK_FILTER, 4: consecutive qualified cycles required in FILTER; 1 <= LOCK_FILTER <= 255.

Ports:
- clk, in, 1: clock.
- nreset, in, 1: reset, synchronous, active-low.
- pll_locked_async, in, 1: PLL lock indicator, asynchronous to clk.
- ext_rst_n_async, in, 1: external reset, active-low, asynchronous to clk.
- sw_rst_req, in, 1: single-cycle software reset request, clk domain.
- rst_n_out, out, NUM_OUT: sequenced active-low resets, registered.
- all_released, out, 1: high when every rst_n_out bit is high.
- state, out, 2: current FSM state; ASSERT=0, FILTER=1, RELEASE=2, RUN=3.
- fault_cnt, out, 8: number of lock-loss aborts, saturating at 255.

Behaviour:
- nreset=0 at a clk edge resets all registers on that edge:
  - state=ASSERT, rst_n_out=0, all_released=0, fault_cnt=0.
  - Counters and release index = 0.
  - Synchronizer flops = 0, which reads as "unlocked / reset asserted".
- Synchronizers: 2 stages each. lock_s and ext_s lag the async inputs by 2 edges.
- qual = lock_s & ext_s.
- All outputs are registered and change only on clk edges.

FSM:
- ASSERT:
  - rst_n_out all 0, all_released 0.
  - hold_cnt increments each cycle.
  - When hold_cnt == DELAY-1: go to FILTER and clear hold_cnt.
  - sw_rst_req in ASSERT: clears hold_cnt, so the full DELAY hold restarts.
  - qual is ignored in ASSERT.
- FILTER:
  - qual=1: filt_cnt increments. When it reaches LOCK_FILTER: go to RELEASE with stag_cnt=0 and idx=0.
  - qual=0: filt_cnt clears to 0; stay in FILTER; fault_cnt does not change.
  - sw_rst_req: go to ASSERT.
- RELEASE:
  - stag_cnt increments each cycle.
  - When stag_cnt == DELAY-1: set rst_n_out[idx]=1, clear stag_cnt, increment idx.
  - When the released bit is idx == NUM_OUT-1: go to RUN, and set all_released=1 on the same edge.
  - Net effect: bit i goes high (i+1)*DELAY edges after the RELEASE-entry edge.
  - Released bits stay high.
- RUN: hold all outputs high.

Abort (RELEASE or RUN):
- Trigger: qual=0 or sw_rst_req=1.
- On the next edge: state=ASSERT, rst_n_out all 0, all_released=0, all counters cleared.
- fault_cnt increments (saturating at 255) only when lock_s=0 caused the abort.
- Simultaneous sw_rst_req and lock_s=0: a single abort, and fault_cnt still increments.
- ext_s=0 alone, or sw_rst_req alone: abort, no fault_cnt change.

Boundaries:
- DELAY=1: hold is 1 cycle, and releases occur on consecutive edges.
- NUM_OUT=1: RELEASE goes straight to RUN on the first release.
- A pulse on an async input shorter than one clk period may be missed; this is accepted.
- Worst-case latency from an async input falling to rst_n_out=0 is 3 edges (2 synchronizer + 1 register).

Test Plan:
1. Power-up: NUM_OUT=3, DELAY=16, LOCK_FILTER=4; lock=1, ext=1 before nreset release -> ASSERT lasts 16 cycles; FILTER lasts 4 cycles; rst_n_out 000->001->011->111 at +16/+32/+48 edges after RELEASE entry; all_released rises with bit 2; state=3.
2. In RUN, drop pll_locked_async for 2 cycles -> rst_n_out=000 within 3 edges; state=0; fault_cnt=1; full sequence repeats after lock returns.
3. In RELEASE with rst_n_out=001, pulse sw_rst_req 1 cycle -> next edge rst_n_out=000, state=ASSERT, fault_cnt unchanged; sw_rst_req again 5 cycles later -> hold restarts, 16 more cycles in ASSERT.
4. In FILTER, lock pattern 1,1,1,0 repeated -> remains state=1 and rst_n_out=000; then 4 consecutive 1s -> RELEASE.
5. 260 lock-loss aborts from RUN -> fault_cnt saturates at 255; ext_rst_n_async low in RUN -> abort with fault_cnt unchanged.
6. nreset=0 for 1 edge in RUN -> that edge all outputs return to reset values (rst_n_out=000, all_released=0, fault_cnt=0, state=0).

Source files
------------

// File: rtl/rst_sequencer.sv
// Board-level reset controller: synchronizes PLL lock and the external reset button,
// then releases NUM_OUT active-low resets one at a time with a fixed gap.
module rst_sequencer #(
    parameter int NUM_OUT     = 3,
    parameter int DELAY_W     = 8,
    parameter int DELAY       = 16,
    parameter int LOCK_FILTER = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               pll_locked_async,
    input  logic               ext_rst_n_async,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               all_released,
    output logic [1:0]         state,
    output logic [7:0]         fault_cnt
);

    localparam int                 IDX_W       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [DELAY_W-1:0] LAST_TICK   = DELAY_W'(DELAY - 1);
    localparam logic [7:0]         FILT_TARGET = 8'(LOCK_FILTER);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e             cur_state;
    state_e             nxt_state;
    logic               lock_meta;
    logic               lock_s;
    logic               ext_meta;
    logic               ext_s;
    logic               qual;
    logic               abort;
    logic [DELAY_W-1:0] hold_cnt;
    logic [DELAY_W-1:0] hold_nxt;
    logic [DELAY_W-1:0] stag_cnt;
    logic [DELAY_W-1:0] stag_nxt;
    logic [7:0]         filt_cnt;
    logic [7:0]         filt_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [NUM_OUT-1:0] rst_n_nxt;
    logic               all_rel_nxt;
    logic [7:0]         fault_nxt;

    // Reset value 0 on both synchronizers reads as "unlocked / button pressed".
    always_ff @(posedge clk) begin
        if (!nreset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            ext_meta  <= 1'b0;
            ext_s     <= 1'b0;
        end else begin
            lock_meta <= pll_locked_async;
            lock_s    <= lock_meta;
            ext_meta  <= ext_rst_n_async;
            ext_s     <= ext_meta;
        end
    end

    assign qual = lock_s & ext_s;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cur_state    <= ST_ASSERT;
            hold_cnt     <= '0;
            stag_cnt     <= '0;
            filt_cnt     <= '0;
            idx          <= '0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
            fault_cnt    <= '0;
        end else begin
            cur_state    <= nxt_state;
            hold_cnt     <= hold_nxt;
            stag_cnt     <= stag_nxt;
            filt_cnt     <= filt_nxt;
            idx          <= idx_nxt;
            rst_n_out    <= rst_n_nxt;
            all_released <= all_rel_nxt;
            fault_cnt    <= fault_nxt;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        hold_nxt    = hold_cnt;
        stag_nxt    = stag_cnt;
        filt_nxt    = filt_cnt;
        idx_nxt     = idx;
        rst_n_nxt   = rst_n_out;
        all_rel_nxt = all_released;
        fault_nxt   = fault_cnt;
        abort       = 1'b0;

        case (cur_state)
            ST_ASSERT: begin
                rst_n_nxt   = '0;
                all_rel_nxt = 1'b0;
                if (sw_rst_req) begin
                    hold_nxt = '0;
                end else if (hold_cnt == LAST_TICK) begin
                    hold_nxt  = '0;
                    filt_nxt  = '0;
                    nxt_state = ST_FILTER;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_FILTER: begin
                if (sw_rst_req) begin
                    filt_nxt  = '0;
                    nxt_state = ST_ASSERT;
                end else if (!qual) begin
                    filt_nxt = '0;
                end else if (filt_cnt + 8'd1 == FILT_TARGET) begin
                    filt_nxt  = '0;
                    stag_nxt  = '0;
                    idx_nxt   = '0;
                    nxt_state = ST_RELEASE;
                end else begin
                    filt_nxt = filt_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!qual || sw_rst_req) begin
                    abort = 1'b1;
                end else if (stag_cnt == LAST_TICK) begin
                    stag_nxt = '0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx == IDX_W'(i)) begin
                            rst_n_nxt[i] = 1'b1;
                        end
                    end
                    // The last release also flags completion on the same edge.
                    if (idx == LAST_IDX) begin
                        idx_nxt     = '0;
                        all_rel_nxt = 1'b1;
                        nxt_state   = ST_RUN;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    stag_nxt = stag_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!qual || sw_rst_req) begin
                    abort = 1'b1;
                end
            end
            default: begin
                nxt_state = ST_ASSERT;
            end
        endcase

        // Only a lost lock counts as a fault, even when a software request coincides.
        if (abort) begin
            nxt_state   = ST_ASSERT;
            rst_n_nxt   = '0;
            all_rel_nxt = 1'b0;
            hold_nxt    = '0;
            stag_nxt    = '0;
            filt_nxt    = '0;
            idx_nxt     = '0;
            if (!lock_s && (fault_cnt != 8'hFF)) begin
                fault_nxt = fault_cnt + 8'd1;
            end
        end
    end

    assign state = cur_state;

endmodule
